// File: rtl/alu_issue_sched_pkg.sv
// Shared types and helpers for the ALU issue scheduler.
package alu_issue_sched_pkg;

  localparam int unsigned ARCH_W    = 5;
  localparam int unsigned DP_DEF    = 4;
  localparam int unsigned RNBIT_DEF = 2;
  localparam int unsigned TW        = ARCH_W + RNBIT_DEF;

  // Per-slot update selector driven by the queue controller.
  typedef enum logic [1:0] {
    SLOT_HOLD  = 2'd0,
    SLOT_SHIFT = 2'd1,
    SLOT_LOAD  = 2'd2,
    SLOT_CLEAR = 2'd3
  } slot_op_e;

  // Architectural register field of a physical tag of width tw ({arch, rename}).
  function automatic logic [ARCH_W-1:0] arch_of(input logic [31:0] tag, input int unsigned tw);
    return tag[tw-1 -: ARCH_W];
  endfunction

endpackage

// File: rtl/alu_issue_sched_issue_slot.sv
// One issue-queue slot: payload/tag storage, wakeup compare and shift-in mux.
module alu_issue_sched_issue_slot
  import alu_issue_sched_pkg::*;
#(
  parameter int unsigned DW    = 160,
  parameter int unsigned TAG_W = TW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  slot_op_e         op_i,
  input  logic             wb_vld_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic [DW-1:0]    ld_info_i,
  input  logic [TAG_W-1:0] ld_rs1_i,
  input  logic [TAG_W-1:0] ld_rs2_i,
  input  logic             ld_rdy1_i,
  input  logic             ld_rdy2_i,
  input  logic [DW-1:0]    sh_info_i,
  input  logic [TAG_W-1:0] sh_rs1_i,
  input  logic [TAG_W-1:0] sh_rs2_i,
  input  logic             sh_rdy1_i,
  input  logic             sh_rdy2_i,
  output logic             valid_o,
  output logic [DW-1:0]    info_o,
  output logic [TAG_W-1:0] rs1_o,
  output logic [TAG_W-1:0] rs2_o,
  output logic             rdy1_o,
  output logic             rdy2_o,
  output logic             rdy1_c_o,
  output logic             rdy2_c_o
);

  logic             valid_q;
  logic [DW-1:0]    info_q;
  logic [TAG_W-1:0] rs1_q;
  logic [TAG_W-1:0] rs2_q;
  logic             rdy1_q;
  logic             rdy2_q;

  // Ready bits including this cycle's wakeup; also what a shift carries downward.
  assign rdy1_c_o = rdy1_q | (wb_vld_i & (rs1_q == wb_tag_i));
  assign rdy2_c_o = rdy2_q | (wb_vld_i & (rs2_q == wb_tag_i));

  // Slot state update: hold with wakeup, shift from neighbour, load dispatch, or clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      info_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rdy1_q  <= 1'b0;
      rdy2_q  <= 1'b0;
    end else begin
      case (op_i)
        SLOT_HOLD: begin
          rdy1_q <= rdy1_c_o;
          rdy2_q <= rdy2_c_o;
        end
        SLOT_SHIFT: begin
          valid_q <= 1'b1;
          info_q  <= sh_info_i;
          rs1_q   <= sh_rs1_i;
          rs2_q   <= sh_rs2_i;
          rdy1_q  <= sh_rdy1_i;
          rdy2_q  <= sh_rdy2_i;
        end
        SLOT_LOAD: begin
          valid_q <= 1'b1;
          info_q  <= ld_info_i;
          rs1_q   <= ld_rs1_i;
          rs2_q   <= ld_rs2_i;
          rdy1_q  <= ld_rdy1_i;
          rdy2_q  <= ld_rdy2_i;
        end
        SLOT_CLEAR: begin
          valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign valid_o = valid_q;
  assign info_o  = info_q;
  assign rs1_o   = rs1_q;
  assign rs2_o   = rs2_q;
  assign rdy1_o  = rdy1_q;
  assign rdy2_o  = rdy2_q;

endmodule

// File: rtl/alu_issue_sched.sv
// Age-ordered collapsing issue queue feeding the ALU execute unit.
module alu_issue_sched
  import alu_issue_sched_pkg::*;
#(
  parameter int unsigned DW    = 160,
  parameter int unsigned DP    = DP_DEF,
  parameter int unsigned RNBIT = RNBIT_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    dispat_vaild,
  output logic                    dispat_ready,
  input  logic [DW-1:0]           dispat_info,
  input  logic [ARCH_W+RNBIT-1:0] dispat_rs1,
  input  logic [ARCH_W+RNBIT-1:0] dispat_rs2,
  input  logic                    dispat_rs1_rdy,
  input  logic                    dispat_rs2_rdy,
  input  logic                    wb_vaild,
  input  logic [ARCH_W+RNBIT-1:0] wb_rd0,
  input  logic                    flush,
  output logic                    alu_execute_vaild,
  input  logic                    alu_execute_ready,
  output logic [DW-1:0]           alu_execute_info
);

  localparam int unsigned TAG_W = ARCH_W + RNBIT;
  localparam int unsigned CNT_W = $clog2(DP + 1);
  localparam int unsigned IDX_W = $clog2(DP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dispat_ready_q;

  logic [DP-1:0]    slot_vld, slot_rdy1, slot_rdy2, slot_rdy1_c, slot_rdy2_c;
  logic [DW-1:0]    slot_info [DP];
  logic [TAG_W-1:0] slot_rs1  [DP];
  logic [TAG_W-1:0] slot_rs2  [DP];
  slot_op_e         slot_op   [DP];
  logic [DP:0]      vld_ext;

  logic [DP-1:0]    sel_oh;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             push, pop;
  logic             push_rdy1, push_rdy2;

  assign vld_ext = {1'b0, slot_vld};

  // Oldest-ready select: lowest valid slot with both operands ready.
  always_comb begin
    sel_oh  = '0;
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (slot_vld[i] && slot_rdy1[i] && slot_rdy2[i]) begin
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
        sel_idx    = IDX_W'(i);
        sel_any    = 1'b1;
      end
    end
  end

  // Selected payload, forced to zero when nothing is issuable.
  always_comb begin
    alu_execute_info = '0;
    for (int i = 0; i < DP; i++) begin
      if (sel_oh[i]) alu_execute_info = alu_execute_info | slot_info[i];
    end
  end

  assign alu_execute_vaild = sel_any;
  assign dispat_ready      = dispat_ready_q;
  assign pop               = sel_any & alu_execute_ready;
  assign push              = dispat_vaild & dispat_ready_q;

  // Operand readiness captured at dispatch, including x0 sources and same-cycle wakeup.
  assign push_rdy1 = dispat_rs1_rdy | (arch_of(32'(dispat_rs1), TAG_W) == '0)
                   | (wb_vaild & (wb_rd0 == dispat_rs1));
  assign push_rdy2 = dispat_rs2_rdy | (arch_of(32'(dispat_rs2), TAG_W) == '0)
                   | (wb_vaild & (wb_rd0 == dispat_rs2));

  // Per-slot control: collapse above the popped slot, load the new op at the tail.
  always_comb begin
    for (int i = 0; i < DP; i++) begin
      slot_op[i] = SLOT_HOLD;
      if (flush) begin
        slot_op[i] = SLOT_CLEAR;
      end else if (pop && (i >= int'(sel_idx))) begin
        if (vld_ext[i+1])                            slot_op[i] = SLOT_SHIFT;
        else if (push && (i == int'(cnt_q) - 1))    slot_op[i] = SLOT_LOAD;
        else                                         slot_op[i] = SLOT_CLEAR;
      end else if (push && (i == int'(cnt_q))) begin
        slot_op[i] = SLOT_LOAD;
      end
    end
  end

  // Occupancy next state; flush wins over push and pop.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Occupancy and registered dispatch-ready.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q          <= '0;
      dispat_ready_q <= 1'b1;
    end else begin
      cnt_q          <= cnt_d;
      dispat_ready_q <= (cnt_d != CNT_W'(DP));
    end
  end

  for (genvar g = 0; g < DP; g++) begin : g_slot
    logic [DW-1:0]    sh_info;
    logic [TAG_W-1:0] sh_rs1, sh_rs2;
    logic             sh_rdy1, sh_rdy2;

    if (g == DP - 1) begin : g_top
      assign sh_info = '0;
      assign sh_rs1  = '0;
      assign sh_rs2  = '0;
      assign sh_rdy1 = 1'b0;
      assign sh_rdy2 = 1'b0;
    end else begin : g_mid
      assign sh_info = slot_info[g+1];
      assign sh_rs1  = slot_rs1[g+1];
      assign sh_rs2  = slot_rs2[g+1];
      assign sh_rdy1 = slot_rdy1_c[g+1];
      assign sh_rdy2 = slot_rdy2_c[g+1];
    end

    alu_issue_sched_issue_slot #(
      .DW    (DW),
      .TAG_W (TAG_W)
    ) u_slot (
      .clk_i     (CLK),
      .rst_i     (RST),
      .op_i      (slot_op[g]),
      .wb_vld_i  (wb_vaild),
      .wb_tag_i  (wb_rd0),
      .ld_info_i (dispat_info),
      .ld_rs1_i  (dispat_rs1),
      .ld_rs2_i  (dispat_rs2),
      .ld_rdy1_i (push_rdy1),
      .ld_rdy2_i (push_rdy2),
      .sh_info_i (sh_info),
      .sh_rs1_i  (sh_rs1),
      .sh_rs2_i  (sh_rs2),
      .sh_rdy1_i (sh_rdy1),
      .sh_rdy2_i (sh_rdy2),
      .valid_o   (slot_vld[g]),
      .info_o    (slot_info[g]),
      .rs1_o     (slot_rs1[g]),
      .rs2_o     (slot_rs2[g]),
      .rdy1_o    (slot_rdy1[g]),
      .rdy2_o    (slot_rdy2[g]),
      .rdy1_c_o  (slot_rdy1_c[g]),
      .rdy2_c_o  (slot_rdy2_c[g])
    );
  end

endmodule

// File: tb/tb_alu_issue_sched.sv
// Scoreboard bench for alu_issue_sched: expected issue order queued at stimulus time.
module tb_alu_issue_sched;

  localparam int unsigned DW = 160;
  localparam int unsigned TW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          dispat_vaild = 1'b0;
  logic          dispat_ready;
  logic [DW-1:0] dispat_info = '0;
  logic [TW-1:0] dispat_rs1 = '0;
  logic [TW-1:0] dispat_rs2 = '0;
  logic          dispat_rs1_rdy = 1'b0;
  logic          dispat_rs2_rdy = 1'b0;
  logic          wb_vaild = 1'b0;
  logic [TW-1:0] wb_rd0 = '0;
  logic          flush = 1'b0;
  logic          alu_execute_vaild;
  logic          alu_execute_ready = 1'b0;
  logic [DW-1:0] alu_execute_info;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  alu_issue_sched #(.DW(DW), .DP(4), .RNBIT(2)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .dispat_vaild      (dispat_vaild),
    .dispat_ready      (dispat_ready),
    .dispat_info       (dispat_info),
    .dispat_rs1        (dispat_rs1),
    .dispat_rs2        (dispat_rs2),
    .dispat_rs1_rdy    (dispat_rs1_rdy),
    .dispat_rs2_rdy    (dispat_rs2_rdy),
    .wb_vaild          (wb_vaild),
    .wb_rd0            (wb_rd0),
    .flush             (flush),
    .alu_execute_vaild (alu_execute_vaild),
    .alu_execute_ready (alu_execute_ready),
    .alu_execute_info  (alu_execute_info)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_push(input int id, input logic [TW-1:0] rs1, input logic [TW-1:0] rs2,
                            input logic r1, input logic r2);
    dispat_vaild   = 1'b1;
    dispat_info    = DW'(id);
    dispat_rs1     = rs1;
    dispat_rs2     = rs2;
    dispat_rs1_rdy = r1;
    dispat_rs2_rdy = r2;
  endtask

  // Issue monitor: every accepted issue outside flush must match the scoreboard head.
  always @(negedge CLK) begin
    if (!RST && !flush && alu_execute_vaild && alu_execute_ready) begin
      if (exp_q.size() == 0) check("issue_unexpected", DW'(exp_q.size()), DW'(1));
      else                   check("issue_info", alu_execute_info, exp_q.pop_front());
    end
  end

  initial begin
    logic [TW-1:0] tags4 [4];
    logic [TW-1:0] wake4 [4];
    tags4 = '{7'h20, 7'h24, 7'h28, 7'h2C};
    wake4 = '{7'h20, 7'h24, 7'h2C, 7'h30};

    // Reset and idle
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      check("rst_vld",   DW'(alu_execute_vaild), DW'(0));
      check("rst_drdy",  DW'(dispat_ready),      DW'(1));
      check("rst_info",  alu_execute_info,       DW'(0));
    end

    // In-order issue of two ready ops
    tick();
    alu_execute_ready = 1'b1;
    drive_push(1, 7'h01, 7'h7F, 1'b0, 1'b1); exp_q.push_back(DW'(1));
    tick();
    drive_push(2, 7'h7F, 7'h7F, 1'b1, 1'b1); exp_q.push_back(DW'(2));
    @(negedge CLK); check("s2_a_vld", DW'(alu_execute_vaild), DW'(1));
    tick();
    dispat_vaild = 1'b0;
    @(negedge CLK); check("s2_b_vld", DW'(alu_execute_vaild), DW'(1));
    tick();
    @(negedge CLK); check("s2_empty", DW'(alu_execute_vaild), DW'(0));

    // Younger ready op bypasses older waiting op; wakeup releases the older one
    tick();
    drive_push(3, 7'h15, 7'h7F, 1'b0, 1'b1);
    tick();
    drive_push(4, 7'h7F, 7'h7F, 1'b1, 1'b1);
    @(negedge CLK); check("s3_a_wait", DW'(alu_execute_vaild), DW'(0));
    tick();
    dispat_vaild = 1'b0;
    wb_vaild = 1'b1; wb_rd0 = 7'h15;
    exp_q.push_back(DW'(4)); exp_q.push_back(DW'(3));
    @(negedge CLK); check("s3_b_vld", DW'(alu_execute_vaild), DW'(1));
    tick();
    wb_vaild = 1'b0;
    @(negedge CLK); check("s3_a_vld", DW'(alu_execute_vaild), DW'(1));
    tick();
    @(negedge CLK); check("s3_empty", DW'(alu_execute_vaild), DW'(0));

    // Full queue, middle pop with blocked dispatch, then refill and age order
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_push(10 + k, tags4[k], 7'h7F, 1'b0, 1'b1);
    end
    tick();
    dispat_vaild = 1'b0;
    @(negedge CLK);
    check("s4_full_drdy", DW'(dispat_ready), DW'(0));
    check("s4_full_vld",  DW'(alu_execute_vaild), DW'(0));
    tick();
    wb_vaild = 1'b1; wb_rd0 = 7'h28;
    exp_q.push_back(DW'(12));
    tick();
    wb_vaild = 1'b0;
    drive_push(14, 7'h30, 7'h7F, 1'b0, 1'b1);
    @(negedge CLK);
    check("s4_pop_vld",     DW'(alu_execute_vaild), DW'(1));
    check("s4_pop_drdy",    DW'(dispat_ready),      DW'(0));
    tick();
    @(negedge CLK);
    check("s4_after_drdy",  DW'(dispat_ready),      DW'(1));
    tick();
    dispat_vaild = 1'b0;
    alu_execute_ready = 1'b0;
    @(negedge CLK);
    check("s4_refull_drdy", DW'(dispat_ready),      DW'(0));
    tick();
    for (int k = 0; k < 4; k++) begin
      wb_vaild = 1'b1; wb_rd0 = wake4[k];
      tick();
    end
    wb_vaild = 1'b0;
    alu_execute_ready = 1'b1;
    exp_q.push_back(DW'(10)); exp_q.push_back(DW'(11));
    exp_q.push_back(DW'(13)); exp_q.push_back(DW'(14));
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK); check("s4_order_vld", DW'(alu_execute_vaild), DW'(1));
      tick();
    end
    @(negedge CLK); check("s4_empty", DW'(alu_execute_vaild), DW'(0));

    // Push with same-cycle matching wakeup
    tick();
    drive_push(20, 7'h41, 7'h7F, 1'b0, 1'b1);
    wb_vaild = 1'b1; wb_rd0 = 7'h41;
    exp_q.push_back(DW'(20));
    tick();
    dispat_vaild = 1'b0;
    wb_vaild = 1'b0;
    @(negedge CLK); check("s5_vld", DW'(alu_execute_vaild), DW'(1));
    tick();
    @(negedge CLK); check("s5_empty", DW'(alu_execute_vaild), DW'(0));

    // Flush with three entries and a same-cycle push
    alu_execute_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_push(30 + k, 7'h7F, 7'h7F, 1'b1, 1'b1);
    end
    tick();
    drive_push(33, 7'h7F, 7'h7F, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dispat_vaild = 1'b0;
    alu_execute_ready = 1'b1;
    @(negedge CLK);
    check("s6_vld",  DW'(alu_execute_vaild), DW'(0));
    check("s6_drdy", DW'(dispat_ready),      DW'(1));
    check("s6_info", alu_execute_info,       DW'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge CLK); check("s6_idle_vld", DW'(alu_execute_vaild), DW'(0));
    end

    check("sb_drained", DW'(exp_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
